// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the serial adder/subtractor datapath.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Chunk counter width: ceil(log2(n)), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full-adder cell used as the ripple element of each processed chunk.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: consumes WIDTH-bit operands BITS_PER_CYCLE bits per cycle, LSB first.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH < 2 || BITS_PER_CYCLE == 0 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
        $error("serial_adder: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [BITS_PER_CYCLE:0]   c;
    logic [BITS_PER_CYCLE-1:0] s_chk;

    // Operands shift right each RUN cycle, so the current chunk is always the low bits.
    assign c[0] = carry_q;
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_ripple
        full_adder u_fa (
            .a_i (a_q[i]),
            .b_i (b_q[i]),
            .c_i (c[i]),
            .s_o (s_chk[i]),
            .c_o (c[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = (sub == SUB) ? ~b : b;
                    carry_d = (sub == SUB) ? ~cin : cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> BITS_PER_CYCLE;
                b_d     = b_q >> BITS_PER_CYCLE;
                // Result chunks enter at the top and walk down to their final slot.
                sum_d   = (sum_q >> BITS_PER_CYCLE) | (WIDTH'(s_chk) << (WIDTH - BITS_PER_CYCLE));
                carry_d = c[BITS_PER_CYCLE];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cout_d  = c[BITS_PER_CYCLE];
                    ovf_d   = c[BITS_PER_CYCLE] ^ c[BITS_PER_CYCLE-1];
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: BPC=1 and BPC=4 instances against an integer-arithmetic reference.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       sel;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       out_ready;

    logic       in_ready1, out_valid1, cout1, ovf1;
    logic       in_ready4, out_valid4, cout4, ovf4;
    logic [7:0] sum1, sum4;

    logic       in_ready_m, out_valid_m, cout_m, ovf_m;
    logic [7:0] sum_m;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(in_ready1),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid1), .out_ready(out_ready & ~sel),
        .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(in_ready4),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid4), .out_ready(out_ready & sel),
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    assign in_ready_m  = sel ? in_ready4  : in_ready1;
    assign out_valid_m = sel ? out_valid4 : out_valid1;
    assign sum_m       = sel ? sum4       : sum1;
    assign cout_m      = sel ? cout4      : cout1;
    assign ovf_m       = sel ? ovf4       : ovf1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic mc, input logic ms,
                         output logic [7:0] es, output logic ec, output logic eo);
        int ua, ub, sa, sb, ic, r, sr;
        ua = ma; ub = mb; ic = mc;
        sa = $signed(ma); sb = $signed(mb);
        if (!ms) begin
            r  = ua + ub + ic;
            sr = sa + sb + ic;
            ec = (r > 255);
        end else begin
            r  = ua - ub - ic;
            sr = sa - sb - ic;
            ec = (r >= 0);
        end
        es = r[7:0];
        eo = (sr > 127) || (sr < -128);
    endtask

    task automatic run_op(input logic s, input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          input logic ts, input int n, input string tag, input bit bp);
        logic [7:0] es;
        logic       ec, eo;
        int         lat;
        model(ta, tb, tc, ts, es, ec, eo);
        @(negedge clk);
        sel = s;
        #1;
        check({tag, ".in_ready"}, in_ready_m, 1);
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = ~ta; b = 8'($urandom); cin = ~tc; sub = ~ts;
        lat = 0;
        while (!out_valid_m && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, n);
        check({tag, ".sum"}, sum_m, es);
        check({tag, ".cout"}, cout_m, ec);
        check({tag, ".ovf"}, ovf_m, eo);
        check({tag, ".ready_in_done"}, in_ready_m, 0);
        if (bp) begin
            for (int i = 0; i < 5; i++) begin
                a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
                @(negedge clk);
                check({tag, ".bp_valid"}, out_valid_m, 1);
                check({tag, ".bp_ready"}, in_ready_m, 0);
                check({tag, ".bp_sum"}, sum_m, es);
                check({tag, ".bp_flags"}, {cout_m, ovf_m}, {ec, eo});
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".retire_valid"}, out_valid_m, 0);
        check({tag, ".retire_ready"}, in_ready_m, 1);
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.state1", {in_ready1, out_valid1, cout1, ovf1, sum1}, {4'b1000, 8'h00});
        check("reset.state4", {in_ready4, out_valid4, cout4, ovf4, sum4}, {4'b1000, 8'h00});
        rst_n = 1'b1;

        run_op(1'b0, 8'h5A, 8'h33, 1'b0, 1'b0, 8, "add5a33", 1'b0);
        run_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 8, "addff01", 1'b0);
        run_op(1'b0, 8'h7F, 8'h00, 1'b1, 1'b0, 8, "add7f00c", 1'b0);
        run_op(1'b0, 8'h10, 8'h20, 1'b0, 1'b1, 8, "sub1020", 1'b0);
        run_op(1'b0, 8'h80, 8'h01, 1'b0, 1'b1, 8, "sub8001", 1'b0);
        run_op(1'b0, 8'hC3, 8'h3C, 1'b1, 1'b1, 8, "backpressure", 1'b1);

        // Abort an operation partway through RUN with an asynchronous reset.
        @(negedge clk);
        sel = 1'b0; a = 8'hFF; b = 8'h00; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.sum", sum1, 8'h00);
        check("midrst.flags", {cout1, ovf1, out_valid1, in_ready1}, 4'b0001);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 8'h01, 8'h01, 1'b0, 1'b0, 8, "after_rst", 1'b0);

        run_op(1'b1, 8'h5A, 8'h33, 1'b0, 1'b0, 2, "bpc4.add5a33", 1'b0);
        run_op(1'b1, 8'h80, 8'h01, 1'b0, 1'b1, 2, "bpc4.sub8001", 1'b1);

        for (int i = 0; i < 24; i++) begin
            logic s;
            s = 1'(i % 2);
            run_op(s, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), s ? 2 : 8,
                   s ? "rand.bpc4" : "rand.bpc1", 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
